// File: rtl/run_det_arbiter.sv
// Round-robin shared "RUN_LEN consecutive 1s" overlapping detector for NCH bit streams.
// Optional per-channel saturating match counters when MATCH_CNT_EN is defined.
module run_det_arbiter #(
  parameter int NCH     = 4,
  parameter int RUN_LEN = 3,
  parameter int CHW     = $clog2(NCH),
  parameter int CW      = $clog2(RUN_LEN)
`ifdef MATCH_CNT_EN
  ,
  parameter int MCW     = 8
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] bit_in,
  input  logic [NCH-1:0] clr,
  output logic [NCH-1:0] grant,
  output logic           det_valid,
  output logic [CHW-1:0] det_ch,
  output logic           det_z
`ifdef MATCH_CNT_EN
  ,
  input  logic [CHW-1:0] rd_ch,
  output logic [MCW-1:0] match_cnt
`endif
);

  logic [CHW-1:0] ptr;
  logic [CHW-1:0] gnt_idx;
  logic [CHW-1:0] cand;
  logic [NCH-1:0] elig;
  logic           found;
  logic           xfer;
  logic [CW-1:0]  cnt [NCH];
  logic [CW-1:0]  cur;
  logic           gbit;
  logic           hit;
  logic [CW-1:0]  nxt;

  assign elig = req & ~clr;

  // First eligible channel at or after ptr, wrapping from NCH-1 back to 0.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = CHW'((int'(ptr) + k) % NCH);
      if (!found && elig[cand]) begin
        found       = 1'b1;
        gnt_idx     = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  assign xfer = found;
  assign cur  = cnt[gnt_idx];
  assign gbit = bit_in[gnt_idx];
  assign hit  = gbit && (cur == CW'(RUN_LEN - 1));
  // A full run saturates the count so every further 1 also fires.
  assign nxt  = !gbit ? '0 : (hit ? cur : cur + CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      ptr       <= '0;
      det_valid <= 1'b0;
      det_ch    <= '0;
      det_z     <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr[i])
          cnt[i] <= '0;
        else if (xfer && gnt_idx == CHW'(i))
          cnt[i] <= nxt;
      end
      det_valid <= xfer;
      if (xfer) begin
        det_ch <= gnt_idx;
        det_z  <= hit;
        ptr    <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + CHW'(1);
      end else begin
        det_z  <= 1'b0;
      end
    end
  end

`ifdef MATCH_CNT_EN
  logic [MCW-1:0] mcnt [NCH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) mcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr[i])
          mcnt[i] <= '0;
        else if (xfer && hit && gnt_idx == CHW'(i) && mcnt[i] != '1)
          mcnt[i] <= mcnt[i] + MCW'(1);
      end
    end
  end

  assign match_cnt = (int'(rd_ch) < NCH) ? mcnt[rd_ch] : '0;
`endif

endmodule

// File: tb/tb_run_det_arbiter.sv
// Directed self-checking bench for run_det_arbiter (NCH=4, RUN_LEN=3).
// Defining MATCH_CNT_EN also exercises the match counters with MCW=2.
module tb_run_det_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] bit_in = '0;
  logic [3:0] clr = '0;
  logic [3:0] grant;
  logic       det_valid;
  logic [1:0] det_ch;
  logic       det_z;
`ifdef MATCH_CNT_EN
  logic [1:0] rd_ch = 2'd3;
  logic [1:0] match_cnt;
`endif

  int total = 0;
  int bad = 0;

  logic [3:0] gnt_obs;
  logic       dv;
  logic [1:0] dch;
  logic       dz;

  always #5 clk = ~clk;

  run_det_arbiter #(
    .NCH(4),
    .RUN_LEN(3)
`ifdef MATCH_CNT_EN
    , .MCW(2)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .bit_in(bit_in),
    .clr(clr),
    .grant(grant),
    .det_valid(det_valid),
    .det_ch(det_ch),
    .det_z(det_z)
`ifdef MATCH_CNT_EN
    , .rd_ch(rd_ch),
    .match_cnt(match_cnt)
`endif
  );

  // Called at a falling edge: drive, sample grant, clock once, sample results.
  task automatic drive(input logic [3:0] r, input logic [3:0] b, input logic [3:0] c);
    req = r;
    bit_in = b;
    clr = c;
    #1;
    gnt_obs = grant;
    @(posedge clk);
    #1;
    dv  = det_valid;
    dch = det_ch;
    dz  = det_z;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    bit_in = '0;
    clr = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({det_valid, det_ch, det_z} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%b want=0000", {det_valid, det_ch, det_z});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_run();
    logic [5:0] bits = 6'b101111;
    logic [5:0] expz = 6'b001100;
    do_reset();
    for (int n = 0; n < 6; n++) begin
      drive(4'b0001, {3'b000, bits[n]}, 4'b0000);
      total++;
      if (gnt_obs !== 4'b0001 || dv !== 1'b1 || dch !== 2'd0 || dz !== expz[n]) begin
        bad++;
        $display("[TB] FAIL single[%0d] got g=%b v=%b ch=%0d z=%b want g=0001 v=1 ch=0 z=%b",
                 n, gnt_obs, dv, dch, dz, expz[n]);
      end
    end
    drive(4'b0000, 4'b0000, 4'b0000);
    total++;
    if (gnt_obs !== 4'b0000 || dv !== 1'b0 || dch !== 2'd0 || dz !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_idle got g=%b v=%b ch=%0d z=%b want g=0000 v=0 ch=0 z=0",
               gnt_obs, dv, dch, dz);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    logic       ez;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      drive(4'b1111, 4'b1111, 4'b0000);
      eg = 4'b0001 << (n % 4);
      ez = (n >= 8);
      total++;
      if (gnt_obs !== eg || dv !== 1'b1 || dch !== 2'(n % 4) || dz !== ez) begin
        bad++;
        $display("[TB] FAIL rr[%0d] got g=%b v=%b ch=%0d z=%b want g=%b v=1 ch=%0d z=%b",
                 n, gnt_obs, dv, dch, dz, eg, n % 4, ez);
      end
    end
  endtask

  task automatic test_isolation();
    logic [3:0] vr [7] = '{4'b0010, 4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0100, 4'b0100};
    logic [3:0] vb [7] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0100, 4'b0100, 4'b0100};
    logic [1:0] ech [7] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2};
    logic       ezv [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int n = 0; n < 7; n++) begin
      drive(vr[n], vb[n], 4'b0000);
      total++;
      if (gnt_obs !== vr[n] || dv !== 1'b1 || dch !== ech[n] || dz !== ezv[n]) begin
        bad++;
        $display("[TB] FAIL iso[%0d] got g=%b v=%b ch=%0d z=%b want g=%b v=1 ch=%0d z=%b",
                 n, gnt_obs, dv, dch, dz, vr[n], ech[n], ezv[n]);
      end
    end
  endtask

  task automatic test_clear_collision();
    logic [3:0] vr [8] = '{4'b0100, 4'b0100, 4'b0110, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
    logic [3:0] vb [8] = '{4'b0100, 4'b0100, 4'b0110, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
    logic [3:0] vc [8] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    logic [3:0] eg [8] = '{4'b0100, 4'b0100, 4'b0010, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100};
    logic       ev [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] ech [8] = '{2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    logic       ezv [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int n = 0; n < 8; n++) begin
      drive(vr[n], vb[n], vc[n]);
      total++;
      if (gnt_obs !== eg[n] || dv !== ev[n] || dch !== ech[n] || dz !== ezv[n]) begin
        bad++;
        $display("[TB] FAIL clr[%0d] got g=%b v=%b ch=%0d z=%b want g=%b v=%b ch=%0d z=%b",
                 n, gnt_obs, dv, dch, dz, eg[n], ev[n], ech[n], ezv[n]);
      end
    end
    drive(4'b0100, 4'b0100, 4'b0000);
    total++;
    if (gnt_obs !== 4'b0100 || dz !== 1'b1) begin
      bad++;
      $display("[TB] FAIL clr_refill got g=%b z=%b want g=0100 z=1", gnt_obs, dz);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    drive(4'b0001, 4'b0001, 4'b0000);
    drive(4'b0001, 4'b0001, 4'b0000);
    rst = 1'b1;
    req = '0;
    #1;
    total++;
    if ({det_valid, det_ch, det_z} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL midreset_outputs got=%b want=0000", {det_valid, det_ch, det_z});
    end
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0011, 4'b0011, 4'b0000);
    total++;
    if (gnt_obs !== 4'b0001 || dv !== 1'b1 || dch !== 2'd0 || dz !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_first got g=%b v=%b ch=%0d z=%b want g=0001 v=1 ch=0 z=0",
               gnt_obs, dv, dch, dz);
    end
    drive(4'b0001, 4'b0001, 4'b0000);
    total++;
    if (dz !== 1'b0 || dch !== 2'd0) begin
      bad++;
      $display("[TB] FAIL midreset_second got ch=%0d z=%b want ch=0 z=0", dch, dz);
    end
    drive(4'b0001, 4'b0001, 4'b0000);
    total++;
    if (dz !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midreset_third got z=%b want z=1", dz);
    end
  endtask

`ifdef MATCH_CNT_EN
  task automatic test_match_cnt();
    logic [1:0] em;
    do_reset();
    rd_ch = 2'd3;
    for (int n = 0; n < 8; n++) begin
      drive(4'b1000, 4'b1000, 4'b0000);
      em = (n < 2) ? 2'd0 : ((n - 1) >= 3 ? 2'd3 : 2'(n - 1));
      total++;
      if (match_cnt !== em) begin
        bad++;
        $display("[TB] FAIL mcnt[%0d] got=%0d want=%0d", n, match_cnt, em);
      end
    end
    drive(4'b0000, 4'b0000, 4'b1000);
    total++;
    if (match_cnt !== 2'd0) begin
      bad++;
      $display("[TB] FAIL mcnt_clr got=%0d want=0", match_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_run();
    test_round_robin();
    test_isolation();
    test_clear_collision();
    test_reset_mid_run();
`ifdef MATCH_CNT_EN
    test_match_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
